// File: rtl/alu_pkg.sv
// Shared definitions for the operand-loading front end: default widths and FSM phase encodings.
package alu_pkg;

    localparam int NW_DEFAULT          = 4;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        WAIT_LO = 2'b00,
        WAIT_HI = 2'b01,
        FULL    = 2'b10
    } phase_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level and emits a one-cycle pulse on each synchronized rising edge.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // History clears on reset, so a level held high across reset release still yields one pulse.
    assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/operand_loader.sv
// Captures a low then a high nibble on successive button presses and holds the pair until acknowledged.
module operand_loader
    import alu_pkg::*;
#(
    parameter int NW          = NW_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NW-1:0] nib_in,
    input  logic          load_btn,
    input  logic          clear,
    input  logic          ack,
    output logic [NW-1:0] lo_nib,
    output logic [NW-1:0] hi_nib,
    output logic          valid,
    output logic [1:0]    phase,
    output logic          overrun
);

    logic   load_evt;
    phase_t state_q;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (load_btn),
        .pulse(load_evt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LO;
            lo_nib  <= '0;
            hi_nib  <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (clear) begin
            state_q <= WAIT_LO;
            lo_nib  <= '0;
            hi_nib  <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LO: begin
                    valid <= 1'b0;
                    if (load_evt) begin
                        lo_nib  <= nib_in;
                        state_q <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (load_evt) begin
                        hi_nib  <= nib_in;
                        state_q <= FULL;
                        valid   <= 1'b1;
                    end else begin
                        valid   <= 1'b0;
                    end
                end
                FULL: begin
                    // ack wins over a coincident press, which is dropped without flagging overrun.
                    if (ack) begin
                        state_q <= WAIT_LO;
                        valid   <= 1'b0;
                    end else begin
                        valid   <= 1'b1;
                        if (load_evt) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= WAIT_LO;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a cycle-level reference model and literal spot checks.
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] nib_in;
    logic       load_btn;
    logic       clear;
    logic       ack;
    logic [3:0] lo_nib;
    logic [3:0] hi_nib;
    logic       valid;
    logic [1:0] phase;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    operand_loader dut (
        .clk     (clk),
        .rst     (rst),
        .nib_in  (nib_in),
        .load_btn(load_btn),
        .clear   (clear),
        .ack     (ack),
        .lo_nib  (lo_nib),
        .hi_nib  (hi_nib),
        .valid   (valid),
        .phase   (phase),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: a press becomes a load event two edges after it is first sampled,
    // and only when the button was not already high at the edge before that.
    logic [3:0] m_lo, m_hi;
    int         m_phase;
    logic       m_over;
    logic       smp1, smp2, smp3;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lo <= 4'h0; m_hi <= 4'h0; m_phase <= 0; m_over <= 1'b0;
            smp1 <= 1'b0; smp2 <= 1'b0; smp3 <= 1'b0;
        end else begin
            smp1 <= load_btn;
            smp2 <= smp1;
            smp3 <= smp2;
            if (clear) begin
                m_lo <= 4'h0; m_hi <= 4'h0; m_phase <= 0; m_over <= 1'b0;
            end else if (m_phase == 0) begin
                if (smp2 && !smp3) begin m_lo <= nib_in; m_phase <= 1; end
            end else if (m_phase == 1) begin
                if (smp2 && !smp3) begin m_hi <= nib_in; m_phase <= 2; end
            end else begin
                if (ack) m_phase <= 0;
                else if (smp2 && !smp3) m_over <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model", {phase, valid, overrun, hi_nib, lo_nib},
              {m_phase[1:0], (m_phase == 2), m_over, m_hi, m_lo});
    end

    task automatic press(input logic [3:0] n);
        @(negedge clk);
        nib_in   = n;
        load_btn = 1'b1;
        repeat (2) @(negedge clk);
        load_btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; nib_in = 4'h0; load_btn = 1'b0; clear = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_state", {phase, valid, overrun, hi_nib, lo_nib}, 32'h0);

        // First press with explicit latency: captured on the second edge after first sample.
        @(negedge clk); nib_in = 4'h3; load_btn = 1'b1;
        @(posedge clk); @(negedge clk);
        check("lat_edge_k", {30'd0, phase}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("lat_edge_k1", {30'd0, phase}, 32'd0);
        load_btn = 1'b0;
        @(posedge clk); @(negedge clk);
        check("lat_edge_k2_phase", {30'd0, phase}, 32'd1);
        check("lat_edge_k2_lo", {28'd0, lo_nib}, 32'h3);
        repeat (2) @(negedge clk);
        press(4'hA);
        check("pair_3A", {phase, valid, overrun, hi_nib, lo_nib}, {2'b10, 1'b1, 1'b0, 4'hA, 4'h3});

        // Press while FULL is dropped and flagged; ack returns to WAIT_LO keeping overrun.
        press(4'h5);
        check("overrun_set", {phase, valid, overrun, hi_nib, lo_nib}, {2'b10, 1'b1, 1'b1, 4'hA, 4'h3});
        pulse_ack();
        check("ack_keeps_over", {phase, valid, overrun, hi_nib, lo_nib}, {2'b00, 1'b0, 1'b1, 4'hA, 4'h3});
        pulse_ack();
        check("ack_outside_full", {28'd0, phase, valid, overrun}, 32'h1);

        pulse_clear();
        check("clear_all", {phase, valid, overrun, hi_nib, lo_nib}, 32'h0);

        // Event and ack coinciding in FULL: ack wins, overrun untouched.
        press(4'h6);
        press(4'h7);
        @(negedge clk); load_btn = 1'b1;
        @(negedge clk);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0; load_btn = 1'b0;
        check("evt_ack_same", {phase, valid, overrun, hi_nib, lo_nib}, {2'b00, 1'b0, 1'b0, 4'h7, 4'h6});
        repeat (3) @(negedge clk);

        // Clear in WAIT_HI, then a fresh pair.
        press(4'hC);
        check("wait_hi_C", {phase, lo_nib}, {2'b01, 4'hC});
        pulse_clear();
        check("clear_wait_hi", {phase, valid, overrun, hi_nib, lo_nib}, 32'h0);
        press(4'h1);
        press(4'h2);
        check("pair_12", {phase, valid, hi_nib, lo_nib}, {2'b10, 1'b1, 4'h2, 4'h1});
        pulse_ack();

        // Asynchronous reset in WAIT_HI, button held across release.
        press(4'h4);
        check("pre_rst_wait_hi", {phase, lo_nib}, {2'b01, 4'h4});
        @(negedge clk); nib_in = 4'h9; load_btn = 1'b1;
        @(posedge clk); #3 rst = 1'b1;
        #1 check("async_rst", {phase, valid, overrun, hi_nib, lo_nib}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        load_btn = 1'b0;
        repeat (4) @(negedge clk);
        check("held_thru_rst", {phase, valid, hi_nib, lo_nib}, {2'b01, 1'b0, 4'h0, 4'h9});

        // Long hold yields a single capture.
        @(negedge clk); nib_in = 4'h8; load_btn = 1'b1;
        repeat (20) @(negedge clk);
        load_btn = 1'b0;
        repeat (4) @(negedge clk);
        check("long_hold", {phase, valid, overrun, hi_nib, lo_nib}, {2'b10, 1'b1, 1'b0, 4'h8, 4'h9});
        pulse_ack();

        // Single-cycle glitch sampled once yields a single capture.
        @(negedge clk); nib_in = 4'hE; load_btn = 1'b1;
        @(negedge clk); load_btn = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch", {phase, valid, lo_nib}, {2'b01, 1'b0, 4'hE});

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
